// File: rtl/par_serial_tx.sv
// par_serial_tx: byte buffer feeding an MSB-first serializer with COM symbol sync and idle fill.
// Define COM_SYNC_EN to enable the post-reset SYNC sequence; otherwise the block starts in ACTIVE.
module par_serial_tx #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  COM_SYMBOL = 8'hBC,
    parameter int unsigned SYNC_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       active
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam int unsigned SYNC_W = $clog2(SYNC_COUNT + 1);

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

`ifdef COM_SYNC_EN
    localparam state_e RESET_STATE = ST_SYNC;
`else
    localparam state_e RESET_STATE = ST_ACTIVE;
`endif

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        sr_q, sr_d;
    logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [7:0]        mem_q [FIFO_DEPTH];

    logic              boundary_c;
    logic              push_c;
    logic              pop_c;

    assign ready_out = (occ_q != OCC_W'(FIFO_DEPTH));
    assign data_out  = sr_q[7];
    assign active    = (state_q == ST_ACTIVE);

    // Next-state: bit counter, symbol selection, FIFO pointers and occupancy.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 3'd1;
        sr_d       = {sr_q[6:0], 1'b0};
        sync_cnt_d = sync_cnt_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        occ_d      = occ_q;

        boundary_c = (cnt_q == 3'd7);
        push_c     = valid_in & ready_out;
        pop_c      = boundary_c & (state_q == ST_ACTIVE) & (occ_q != '0);

        if (boundary_c) begin
            if (state_q == ST_SYNC) begin
                sr_d       = COM_SYMBOL;
                sync_cnt_d = sync_cnt_q + SYNC_W'(1);
                if (sync_cnt_q == SYNC_W'(SYNC_COUNT - 1)) begin
                    state_d = ST_ACTIVE;
                end
            end else if (pop_c) begin
                sr_d = mem_q[rptr_q];
            end else begin
                sr_d = COM_SYMBOL;
            end
        end

        if (push_c) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rptr_d = rptr_q + PTR_W'(1);
        end

        if (push_c && !pop_c) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!push_c && pop_c) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // Control state; reset starts at the last bit so the first free edge is a boundary.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            cnt_q      <= 3'd7;
            sr_q       <= 8'h00;
            sync_cnt_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            occ_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            sync_cnt_q <= sync_cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            occ_q      <= occ_d;
        end
    end

    // Buffer storage; contents are meaningless once pointers are reset.
    always_ff @(posedge clk_32f) begin
        if (push_c && !reset) begin
            mem_q[wptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_par_serial_tx.sv
// Self-checking bench for par_serial_tx: time-based stream model plus literal symbol checks.
module tb_par_serial_tx;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam logic [7:0]  COM        = 8'hBC;
    localparam int unsigned SYNC_COUNT = 4;
`ifdef COM_SYNC_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    logic       clk_32f;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic       active;

    int checks = 0;
    int errors = 0;
    int tcur   = 0;

    par_serial_tx #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .COM_SYMBOL (COM),
        .SYNC_COUNT (SYNC_COUNT)
    ) dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .active    (active)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: symbol k starts at free-running time t = 8k after reset release.
    logic [7:0] mq [$];
    int         mt = 0;
    logic [7:0] m_sym = 8'h00;
    logic       m_data = 1'b0;
    logic       m_active = 1'b0;
    logic       m_ready = 1'b1;
    logic       m_valid = 1'b0;
    logic       m_last_rst = 1'b1;

    always @(posedge clk_32f) begin
        bit accept;
        int k;
        if (reset) begin
            mq.delete();
            mt         = 0;
            m_sym      = 8'h00;
            m_data     = 1'b0;
            m_active   = !SYNC_EN;
            m_ready    = 1'b1;
            m_valid    = 1'b1;
            m_last_rst = 1'b1;
        end else if (m_valid) begin
            accept = valid_in && (mq.size() != FIFO_DEPTH);
            if (mt % 8 == 0) begin
                k = mt / 8;
                if (SYNC_EN && k < int'(SYNC_COUNT)) m_sym = COM;
                else if (mq.size() > 0)              m_sym = mq.pop_front();
                else                                 m_sym = COM;
            end
            if (accept) mq.push_back(data_in);
            m_data     = m_sym[3'(7 - mt % 8)];
            m_active   = !SYNC_EN || (mt >= 8 * (int'(SYNC_COUNT) - 1));
            m_ready    = (mq.size() != FIFO_DEPTH);
            m_last_rst = 1'b0;
            mt++;
        end
    end

    // Compare every cycle and deserialize the DUT stream into whole symbols.
    logic [7:0] rx_syms [$];
    logic [7:0] rx_b = 8'h00;
    int         rx_n = 0;

    always @(negedge clk_32f) begin
        if (m_valid) begin
            chk("data_out", 32'(data_out), 32'(m_data));
            chk("active", 32'(active), 32'(m_active));
            chk("ready_out", 32'(ready_out), 32'(m_ready));
            if (m_last_rst) begin
                rx_syms.delete();
                rx_n = 0;
            end else begin
                rx_b = {rx_b[6:0], data_out};
                rx_n++;
                if (rx_n == 8) begin
                    rx_syms.push_back(rx_b);
                    rx_n = 0;
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [7:0] d);
        valid_in = v;
        data_in  = d;
        @(posedge clk_32f);
        #1;
        if (!reset) tcur++;
        valid_in = 1'b0;
    endtask

    task automatic idle_to(input int n);
        while (tcur < n) cyc(1'b0, 8'h00);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) cyc(1'b0, 8'h00);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_ready_out", 32'(ready_out), 32'd1);
        chk("rst_active", 32'(active), 32'(!SYNC_EN));
        reset = 1'b0;
        tcur  = 0;
    endtask

    task automatic chk_sym(input string name, input int idx, input logic [7:0] exp);
        logic [8:0] act;
        act = (idx < rx_syms.size()) ? {1'b0, rx_syms[idx]} : 9'h1FF;
        chk(name, 32'(act), 32'(exp));
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;

        if (SYNC_EN) begin
            // Sync sequence, single byte, push on an empty boundary.
            do_reset(3);
            idle_to(24);
            chk("active_before_4th", 32'(active), 32'd0);
            idle_to(25);
            chk("active_after_4th", 32'(active), 32'd1);
            idle_to(35);
            cyc(1'b1, 8'hA5);
            idle_to(56);
            cyc(1'b1, 8'h5A);
            chk("ready_after_bnd_push", 32'(ready_out), 32'd1);
            idle_to(81);
            for (int i = 0; i < 5; i++) chk_sym("sync_com", i, COM);
            chk_sym("a5_sym", 5, 8'hA5);
            chk_sym("com_after_a5", 6, COM);
            chk_sym("bnd_push_com", 7, COM);
            chk_sym("bnd_push_byte", 8, 8'h5A);
            chk_sym("com_after_5a", 9, COM);

            // Fill during SYNC, overflow bytes dropped.
            do_reset(2);
            for (int i = 1; i <= 6; i++) begin
                cyc(1'b1, 8'(i));
                if (i >= 4) chk("ready_full", 32'(ready_out), 32'd0);
            end
            idle_to(32);
            chk("ready_before_pop", 32'(ready_out), 32'd0);
            idle_to(33);
            chk("ready_after_pop", 32'(ready_out), 32'd1);
            idle_to(73);
            for (int i = 0; i < 4; i++) chk_sym("fill_order", 4 + i, 8'(i + 1));
            chk_sym("fill_idle", 8, COM);

            // Reset at bit 3 of a data symbol with two bytes still buffered.
            cyc(1'b1, 8'h11);
            cyc(1'b1, 8'h22);
            cyc(1'b1, 8'h33);
            idle_to(84);
            reset = 1'b1;
            cyc(1'b0, 8'h00);
            chk("midrst_data_out", 32'(data_out), 32'd0);
            chk("midrst_ready", 32'(ready_out), 32'd1);
            chk("midrst_active", 32'(active), 32'd0);
            reset = 1'b0;
            tcur  = 0;
            idle_to(49);
            for (int i = 0; i < 6; i++) chk_sym("midrst_com", i, COM);
        end else begin
            // No sync: byte pushed on the first free edge goes in symbol 1.
            do_reset(3);
            cyc(1'b1, 8'h3C);
            idle_to(19);
            chk("nosync_active", 32'(active), 32'd1);
            cyc(1'b1, 8'hA5);
            idle_to(41);
            chk_sym("nosync_sym0", 0, COM);
            chk_sym("nosync_sym1", 1, 8'h3C);
            chk_sym("nosync_sym2", 2, COM);
            chk_sym("nosync_a5", 3, 8'hA5);
            chk_sym("nosync_sym4", 4, COM);

            do_reset(2);
            for (int i = 1; i <= 6; i++) begin
                cyc(1'b1, 8'(i));
                if (i >= 4) chk("ready_full", 32'(ready_out), 32'd0);
            end
            idle_to(8);
            chk("ready_before_pop", 32'(ready_out), 32'd0);
            idle_to(9);
            chk("ready_after_pop", 32'(ready_out), 32'd1);
            idle_to(49);
            chk_sym("fill_com0", 0, COM);
            for (int i = 0; i < 4; i++) chk_sym("fill_order", 1 + i, 8'(i + 1));
            chk_sym("fill_idle", 5, COM);

            cyc(1'b1, 8'h11);
            cyc(1'b1, 8'h22);
            cyc(1'b1, 8'h33);
            idle_to(60);
            reset = 1'b1;
            cyc(1'b0, 8'h00);
            chk("midrst_data_out", 32'(data_out), 32'd0);
            chk("midrst_ready", 32'(ready_out), 32'd1);
            chk("midrst_active", 32'(active), 32'd1);
            reset = 1'b0;
            tcur  = 0;
            idle_to(41);
            for (int i = 0; i < 5; i++) chk_sym("midrst_com", i, COM);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
